// File: rtl/run_ctrl.sv
// run_ctrl: PC register and run/halt sequencer for the 3BC core.
// Optional single-step support is built when RUN_CTRL_STEP_EN is defined.
module run_ctrl #(
   parameter int              PC_W       = 10,
   parameter int              CNT_W      = 16,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic             BranchRel,
   input  logic [PC_W-1:0]  Target,
   input  logic             Stall,
`ifdef RUN_CTRL_STEP_EN
   input  logic             StepMode,
   input  logic             Step,
`endif
   output logic [PC_W-1:0]  ProgCtr,
   output logic             CountEn,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]      state;
   logic            start_q;
   logic            start_fall;
   logic            adv;
   logic [PC_W-1:0] pc_next;

   assign start_fall = start_q & ~Start;

`ifdef RUN_CTRL_STEP_EN
   logic step_q;

   // Remember last Step level so only its rising edge advances
   always_ff @(posedge Clk) begin
      if (Reset) step_q <= 1'b0;
      else       step_q <= Step;
   end

   assign adv = ~StepMode | (Step & ~step_q);
`else
   assign adv = 1'b1;
`endif

   // Next sequential or branch address, wrapping modulo 2^PC_W
   always_comb begin
      pc_next = ProgCtr + PC_W'(1);
      if (BranchEn) begin
         if (BranchRel) pc_next = ProgCtr + Target;
         else           pc_next = Target;
      end
   end

   // Instruction is being consumed this cycle
   assign CountEn = (state == S_RUN) & ~Stall & adv;

   // Run/halt state machine with PC and cycle counter
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         ProgCtr    <= START_ADDR;
         Done       <= 1'b0;
         CycleCount <= '0;
      end else begin
         start_q <= Start;
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  state      <= S_ARMED;
                  ProgCtr    <= START_ADDR;
                  CycleCount <= '0;
                  Done       <= 1'b0;
               end
            end
            S_ARMED: begin
               if (start_fall) state <= S_RUN;
            end
            S_RUN: begin
               if (Start) begin
                  state      <= S_ARMED;
                  ProgCtr    <= START_ADDR;
                  CycleCount <= '0;
               end else if (adv) begin
                  if (CycleCount != '1)
                     CycleCount <= CycleCount + CNT_W'(1);
                  if (Halt) begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                  end else if (!Stall) begin
                     ProgCtr <= pc_next;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed plus random checks of run_ctrl
// against a behavioural model of the run sequencer.
module tb_run_ctrl;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Halt;
   logic        BranchEn;
   logic        BranchRel;
   logic [9:0]  Target;
   logic        Stall;
   logic        StepMode;
   logic        Step;
   logic [9:0]  ProgCtr;
   logic        CountEn;
   logic        Done;
   logic [15:0] CycleCount;

   int total = 0;
   int bad   = 0;

   // behavioural model
   bit m_armed, m_run, m_done, m_prev, m_sprev;
   int m_pc, m_cnt;
   int en_hits;

   run_ctrl #(.PC_W(10), .CNT_W(16), .START_ADDR(10'd0)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Halt       (Halt),
      .BranchEn   (BranchEn),
      .BranchRel  (BranchRel),
      .Target     (Target),
      .Stall      (Stall),
`ifdef RUN_CTRL_STEP_EN
      .StepMode   (StepMode),
      .Step       (Step),
`endif
      .ProgCtr    (ProgCtr),
      .CountEn    (CountEn),
      .Done       (Done),
      .CycleCount (CycleCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit step_ok();
      bit rise;
`ifdef RUN_CTRL_STEP_EN
      rise = Step && !m_sprev;
      return !StepMode || rise;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_clear();
      m_armed = 0; m_run = 0; m_done = 0;
      m_prev = 0; m_sprev = 0;
      m_pc = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      bit go;
      go = step_ok();
      if (Reset) begin
         model_clear();
         return;
      end
      if (m_armed) begin
         if (m_prev && !Start) begin
            m_armed = 0; m_run = 1;
         end
      end else if (m_run) begin
         if (Start) begin
            m_run = 0; m_armed = 1; m_pc = 0; m_cnt = 0;
         end else if (go) begin
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            if (Halt) begin
               m_run = 0; m_done = 1;
            end else if (!Stall) begin
               if (!BranchEn)      m_pc = (m_pc + 1) % 1024;
               else if (BranchRel) m_pc = (m_pc + int'(Target)) % 1024;
               else                m_pc = int'(Target);
            end
         end
      end else if (Start) begin
         m_armed = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
      m_prev  = Start;
      m_sprev = Step;
   endtask

   // one clock: check comb output, clock, update model, check registers
   task automatic cyc();
      bit ce;
      #1;
      ce = m_run && !Stall && step_ok();
      chk("count_en", CountEn, ce);
      if (CountEn === 1'b1) en_hits++;
      @(posedge Clk);
      model_edge();
      #1;
      chk("prog_ctr", ProgCtr, m_pc);
      chk("done", Done, m_done);
      chk("cycle_count", CycleCount, m_cnt);
   endtask

   task automatic idle_in();
      Reset = 0; Start = 0; Halt = 0; BranchEn = 0;
      BranchRel = 0; Target = '0; Stall = 0;
   endtask

   int c0;

   initial begin
      idle_in();
      StepMode = 0; Step = 0; en_hits = 0;
      Reset = 1;
      repeat (2) @(posedge Clk);
      #1;
      model_clear();
      chk("rst_pc", ProgCtr, 0);
      chk("rst_done", Done, 0);
      chk("rst_cnt", CycleCount, 0);
      chk("rst_ce", CountEn, 0);
      Reset = 0;

      // arm for 3 cycles, launch on fall
      Start = 1;
      repeat (3) cyc();
      Start = 0;
      cyc();
      chk("first_pc", ProgCtr, 0);
      repeat (5) cyc();
      chk("seq_pc", ProgCtr, 5);
      chk("seq_cnt", CycleCount, 5);
      #1 chk("seq_ce", CountEn, 1);
      repeat (3) cyc();
      chk("pc8", ProgCtr, 8);

      // absolute then negative relative
      BranchEn = 1; Target = 10'h020;
      cyc();
      chk("br_abs", ProgCtr, 10'h020);
      BranchRel = 1; Target = 10'h3FC;
      cyc();
      chk("br_rel_neg", ProgCtr, 10'h01C);

      // wrap at top of address space
      BranchRel = 0; Target = 10'h3FF;
      cyc();
      BranchEn = 0;
      cyc();
      chk("wrap_inc", ProgCtr, 0);
      BranchEn = 1; Target = 10'h3FF;
      cyc();
      BranchRel = 1; Target = 10'h002;
      cyc();
      chk("wrap_rel", ProgCtr, 1);

      // stall holds PC but counts
      BranchRel = 0; Target = 10'h004;
      cyc();
      BranchEn = 0;
      c0 = m_cnt;
      Stall = 1;
      repeat (3) cyc();
      chk("stall_pc", ProgCtr, 4);
      chk("stall_cnt", CycleCount, c0 + 3);
      #1 chk("stall_ce", CountEn, 0);
      Stall = 0;

      // halt beats branch
      Halt = 1; BranchEn = 1; Target = 10'h055;
      cyc();
      chk("halt_done", Done, 1);
      chk("halt_pc", ProgCtr, 4);
      idle_in();
      repeat (2) cyc();
      chk("done_frz", ProgCtr, 4);

      // restart from DONE, then reset mid-run
      Start = 1;
      cyc();
      chk("rearm_cnt", CycleCount, 0);
      chk("rearm_done", Done, 0);
      Start = 0;
      cyc();
      BranchEn = 1; Target = 10'h015;
      cyc();
      chk("pc15", ProgCtr, 10'h015);
      idle_in();
      Reset = 1;
      cyc();
      chk("mid_rst_pc", ProgCtr, 0);
      chk("mid_rst_cnt", CycleCount, 0);
      Reset = 0;
      cyc();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         Reset     = ($urandom % 150) == 0;
         Start     = ($urandom % 30) == 0;
         Halt      = ($urandom % 25) == 0;
         BranchEn  = ($urandom % 4) == 0;
         BranchRel = $urandom % 2;
         Target    = 10'($urandom);
         Stall     = ($urandom % 5) == 0;
         cyc();
      end
      idle_in();

`ifdef RUN_CTRL_STEP_EN
      // single step: three pulses, four cycles apart
      StepMode = 1;
      Start = 1;
      cyc();
      Start = 0;
      cyc();
      en_hits = 0;
      for (int k = 0; k < 3; k++) begin
         Step = 1;
         cyc();
         Step = 0;
         repeat (3) cyc();
      end
      chk("step_pc", ProgCtr, 3);
      chk("step_cnt", CycleCount, 3);
      chk("step_hits", en_hits, 3);
      StepMode = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
